util_axis_pad: RTL and testbench
================================

Name: util_axis_pad

Overview:
Streaming successor to the combinational sample padder. Adds or removes bits on every sample of a multi-sample AXI-Stream beat, with optional round-half-up and saturation when narrowing. Beats are registered behind a 2-entry skid buffer, giving full throughput and a registered s_axis_ready. Sits between converter data paths and DMA/packers in ADC and DAC chains.

Parameters:
NUM_OF_SAMPLES, 2, samples per beat (>=1)
IN_BITS_PER_SAMPLE, 16, input sample width (>=2)
OUT_BITS_PER_SAMPLE, 16, output sample width (>=2)
PADDING_TO_MSB_LSB_N, 0, 1: bits added/removed at MSB side; 0: at LSB side
SIGN_EXTEND, 1, 1: samples are two's complement; 0: unsigned
ROUND, 0, LSB removal only: 1 = round half up, saturate on carry; 0 = floor truncate
SATURATE, 0, MSB removal only: 1 = clamp out-of-range samples; 0 = wrap (drop MSBs)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
s_axis_valid  in  1  input beat valid
s_axis_ready  out  1  input beat accepted when valid&ready
s_axis_data  in  NUM_OF_SAMPLES*IN_BITS_PER_SAMPLE  samples, sample i at [i*IN +: IN]
s_axis_last  in  1  end of packet, passed through
m_axis_valid  out  1  output beat valid
m_axis_ready  in  1  downstream ready
m_axis_data  out  NUM_OF_SAMPLES*OUT_BITS_PER_SAMPLE  converted samples, same ordering
m_axis_last  out  1  last of the beat
ovf_sticky  out  1  set when any sample of an accepted beat was clamped
ovf_clear  in  1  clears ovf_sticky

Behaviour:
- One clock; reset is synchronous and active-low. While resetn=0 and in the first cycle it is sampled: m_axis_valid=0, m_axis_data=0, m_axis_last=0, s_axis_ready=0, ovf_sticky=0, both skid entries invalid. s_axis_ready=1 in the cycle after resetn is sampled high. A reset mid-packet discards all held beats.
- Per-sample transform F, D=|IN-OUT|:
  - IN==OUT: pass through.
  - IN<OUT, P=1: prepend D copies of (MSB & SIGN_EXTEND).
  - IN<OUT, P=0: append D zero bits.
  - IN>OUT, P=0, ROUND=0: take the top OUT bits.
  - IN>OUT, P=0, ROUND=1: add 2^(D-1) in IN+1 bits (sign-extended if SIGN_EXTEND), shift right by D. If the result exceeds the OUT range, output the max (signed 2^(OUT-1)-1, unsigned all-ones) and flag overflow. Negative values never overflow.
  - IN>OUT, P=1, SATURATE=0: take the low OUT bits, no flag.
  - IN>OUT, P=1, SATURATE=1: if the value is outside the OUT range (signed or unsigned per SIGN_EXTEND), clamp to max/min and flag overflow.
- Pipeline: F is applied combinationally on the input. The result is captured into the output register (state ONE) or the skid register (state TWO). Latency is 1 cycle from acceptance to m_axis_valid when not stalled.
- State machine:
  - EMPTY: m_valid=0, s_ready=1.
  - ONE: m_valid=1, s_ready=1.
  - TWO: m_valid=1, s_ready=0.
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on pop without accept.
  - ONE -> ONE on pop+accept or on idle.
  - ONE -> TWO on accept without pop.
  - TWO -> ONE on pop: the skid entry moves to the output register.
- s_axis_ready is a register output, never combinational from m_axis_ready.
- Sustains 1 beat/cycle while m_axis_ready=1. Order is preserved; no beat is lost or duplicated. m_axis_data and m_axis_last are stable while m_valid & ~m_ready.
- ovf_sticky: set in the cycle after accepting a flagged beat. ovf_clear clears it next cycle. Set wins over a simultaneous clear.

Decomposition:
- Shared include util_axis_pad_defs.vh holds the skid state encodings (EMPTY/ONE/TWO) and the range-limit helper localparams (signed/unsigned max/min for a width).
- Sub-module util_axis_pad_sample: combinational single-sample F with overflow output, instantiated NUM_OF_SAMPLES times in a generate loop. Overflow outputs are OR-reduced per beat.

Test Plan:
- Reset: hold resetn=0 3 cycles with s_valid=1 -> m_valid=0, m_data=0, ovf_sticky=0, s_ready=0; s_ready=1 on the cycle after release.
- IN=12, OUT=16, SIGN_EXTEND=1:
  - P=1: 0x800->0xF800, 0x7FF->0x07FF.
  - P=0: 0x800->0x8000.
  - SIGN_EXTEND=0, P=1: 0x800->0x0800.
- IN=16, OUT=12, P=0, ROUND=1, SIGN_EXTEND=1: 0x1238->0x124; 0x1237->0x123; 0xFFF8->0x000; 0x7FF8->0x7FF with ovf_sticky=1 next cycle.
- IN=16, OUT=8, P=1, SATURATE=1:
  - SIGN_EXTEND=1: 0x0123->0x7F (ovf); 0xFF80->0x80 (no ovf); 0xFE00->0x80 (ovf).
  - SIGN_EXTEND=0: 0x0100->0xFF (ovf).
- Backpressure: 8 beats with data 1..8, last on beat 8, m_ready pattern 1,0,0,1 repeating -> output is 1..8 in order, last only on 8, s_ready low only in TWO. With m_ready=1 constant, one beat out per cycle after 1-cycle latency.
- Overflow clear: ovf_clear=1 in the same cycle a flagged beat is captured -> ovf_sticky stays 1. ovf_clear=1 alone -> ovf_sticky=0 next cycle.

Source files
------------

// File: rtl/util_axis_pad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : util_axis_pad_pkg
//  Description : Shared definitions for the streaming sample padder:
//                - encodings for the skid-buffer states (EMPTY/ONE/TWO)
//                - helpers that return the max/min code of a signed or
//                  unsigned field of a given width
//  Revision    : 1.0 - initial release
// ============================================================================
package util_axis_pad_pkg;

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = c_ST_EMPTY,
        ST_ONE   = c_ST_ONE,
        ST_TWO   = c_ST_TWO
    } skid_state_t;

    // Largest code of a width-bit field (signed: 0111..1, unsigned: 111..1).
    function automatic logic [63:0] limit_max(input int width, input bit is_signed);
        if (is_signed) begin
            return (64'd1 << (width - 1)) - 64'd1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

    // Smallest code of a width-bit field (signed: 100..0, unsigned: 0).
    function automatic logic [63:0] limit_min(input int width, input bit is_signed);
        if (is_signed) begin
            return 64'd1 << (width - 1);
        end
        return 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/util_axis_pad_if.sv
`default_nettype none
// ============================================================================
//  Module      : util_axis_pad_if
//  Description : AXI-Stream beat bundle (valid/ready/data/last).
//                master modport drives valid/data/last and reads ready;
//                slave modport is the mirror image.
//  Revision    : 1.0 - initial release
// ============================================================================
interface util_axis_pad_if #(
    parameter int DATA_W = 32
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);
endinterface
`default_nettype wire

// File: rtl/util_axis_pad_sample.sv
`default_nettype none
// ============================================================================
//  Module      : util_axis_pad_sample
//  Description : Combinational width conversion of a single sample.
//                Widening pads at MSB (sign/zero extension) or LSB (zeros).
//                Narrowing drops LSBs (floor, or round-half-up with
//                saturation on carry) or MSBs (wrap, or clamp).
//  Ports       : i_din  - input sample
//                o_dout - converted sample
//                o_ovf  - sample was clamped
//  Revision    : 1.0 - initial release
// ============================================================================
module util_axis_pad_sample
    import util_axis_pad_pkg::*;
#(
    parameter int IN_BITS_PER_SAMPLE   = 16,
    parameter int OUT_BITS_PER_SAMPLE  = 16,
    parameter int PADDING_TO_MSB_LSB_N = 0,
    parameter int SIGN_EXTEND          = 1,
    parameter int ROUND                = 0,
    parameter int SATURATE             = 0
) (
    input  wire logic [IN_BITS_PER_SAMPLE-1:0]  i_din,
    output logic      [OUT_BITS_PER_SAMPLE-1:0] o_dout,
    output logic                                o_ovf
);
    localparam int   IW       = IN_BITS_PER_SAMPLE;
    localparam int   OW       = OUT_BITS_PER_SAMPLE;
    localparam logic c_SE_BIT = (SIGN_EXTEND != 0);

    generate
        if (IW == OW) begin : g_pass
            assign o_dout = i_din;
            assign o_ovf  = 1'b0;
        end else if (IW < OW) begin : g_widen
            localparam int c_D = OW - IW;
            if (PADDING_TO_MSB_LSB_N != 0) begin : g_msb
                assign o_dout = {{c_D{i_din[IW-1] & c_SE_BIT}}, i_din};
            end else begin : g_lsb
                assign o_dout = {i_din, {c_D{1'b0}}};
            end
            assign o_ovf = 1'b0;
        end else if (PADDING_TO_MSB_LSB_N == 0) begin : g_lsb_cut
            localparam int c_D = IW - OW;
            if (ROUND != 0) begin : g_round
                localparam logic [63:0] c_MAX_FULL = limit_max(OW, SIGN_EXTEND != 0);
                localparam logic [OW-1:0] c_MAX = c_MAX_FULL[OW-1:0];
                localparam logic [IW:0] c_HALF = {{IW{1'b0}}, 1'b1} << (c_D - 1);
                logic [IW:0] w_ext;
                logic [OW:0] w_shr;
                logic        w_ovf;
                // One guard bit keeps the +half from wrapping; the shifted
                // value is OW+1 bits so the carry into the sign is visible.
                assign w_ext = {i_din[IW-1] & c_SE_BIT, i_din};
                assign w_shr = (OW+1)'((w_ext + c_HALF) >> c_D);
                if (SIGN_EXTEND != 0) begin : g_signed
                    // Only a positive result can spill past the max code.
                    assign w_ovf = ~w_shr[OW] & w_shr[OW-1];
                end else begin : g_unsigned
                    assign w_ovf = w_shr[OW];
                end
                assign o_dout = w_ovf ? c_MAX : w_shr[OW-1:0];
                assign o_ovf  = w_ovf;
            end else begin : g_trunc
                logic w_unused_lsb;
                assign w_unused_lsb = ^i_din[c_D-1:0];
                assign o_dout       = i_din[IW-1 -: OW];
                assign o_ovf        = 1'b0;
            end
        end else begin : g_msb_cut
            localparam int c_D = IW - OW;
            if (SATURATE != 0) begin : g_sat
                localparam logic [63:0] c_MAX_FULL = limit_max(OW, SIGN_EXTEND != 0);
                localparam logic [63:0] c_MIN_FULL = limit_min(OW, SIGN_EXTEND != 0);
                localparam logic [OW-1:0] c_MAX = c_MAX_FULL[OW-1:0];
                localparam logic [OW-1:0] c_MIN = c_MIN_FULL[OW-1:0];
                logic w_in_range;
                if (SIGN_EXTEND != 0) begin : g_signed
                    // Fits when every dropped bit equals the new sign bit.
                    logic [c_D:0] w_top;
                    assign w_top      = i_din[IW-1:OW-1];
                    assign w_in_range = (&w_top) | ~(|w_top);
                    assign o_dout     = w_in_range ? i_din[OW-1:0] :
                                        (i_din[IW-1] ? c_MIN : c_MAX);
                end else begin : g_unsigned
                    assign w_in_range = ~(|i_din[IW-1:OW]);
                    assign o_dout     = w_in_range ? i_din[OW-1:0] : c_MAX;
                end
                assign o_ovf = ~w_in_range;
            end else begin : g_wrap
                logic w_unused_msb;
                assign w_unused_msb = ^i_din[IW-1:OW];
                assign o_dout       = i_din[OW-1:0];
                assign o_ovf        = 1'b0;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/util_axis_pad.sv
`default_nettype none
// ============================================================================
//  Module      : util_axis_pad
//  Description : Streaming sample padder. Converts every sample of an
//                AXI-Stream beat and holds results in a 2-entry skid buffer
//                (output register + skid register) so that s_axis.ready is
//                registered and throughput is one beat per cycle.
//  Ports       : clk        - clock
//                resetn     - synchronous active-low reset
//                s_axis     - input stream (slave modport)
//                m_axis     - output stream (master modport)
//                ovf_sticky - some sample of an accepted beat was clamped
//                ovf_clear  - clears ovf_sticky (a new overflow wins)
//  Revision    : 1.0 - initial release
// ============================================================================
module util_axis_pad
    import util_axis_pad_pkg::*;
#(
    parameter int NUM_OF_SAMPLES       = 2,
    parameter int IN_BITS_PER_SAMPLE   = 16,
    parameter int OUT_BITS_PER_SAMPLE  = 16,
    parameter int PADDING_TO_MSB_LSB_N = 0,
    parameter int SIGN_EXTEND          = 1,
    parameter int ROUND                = 0,
    parameter int SATURATE             = 0
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    util_axis_pad_if.slave   s_axis,
    util_axis_pad_if.master  m_axis,
    output logic             ovf_sticky,
    input  wire logic        ovf_clear
);
    localparam int c_OUT_W = NUM_OF_SAMPLES * OUT_BITS_PER_SAMPLE;

    skid_state_t          r_state;
    skid_state_t          w_state_nxt;
    logic [c_OUT_W-1:0]   w_conv;
    logic [c_OUT_W-1:0]   r_out_data;
    logic [c_OUT_W-1:0]   r_skid_data;
    logic                 r_out_last;
    logic                 r_skid_last;
    logic                 r_s_ready;
    logic                 r_ovf;
    logic [NUM_OF_SAMPLES-1:0] w_ovf_lane;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_load_out_in;
    logic                 w_load_out_skid;
    logic                 w_load_skid;

    generate
        for (genvar i = 0; i < NUM_OF_SAMPLES; i++) begin : g_lane
            util_axis_pad_sample #(
                .IN_BITS_PER_SAMPLE   (IN_BITS_PER_SAMPLE),
                .OUT_BITS_PER_SAMPLE  (OUT_BITS_PER_SAMPLE),
                .PADDING_TO_MSB_LSB_N (PADDING_TO_MSB_LSB_N),
                .SIGN_EXTEND          (SIGN_EXTEND),
                .ROUND                (ROUND),
                .SATURATE             (SATURATE)
            ) u_sample (
                .i_din  (s_axis.data[i*IN_BITS_PER_SAMPLE +: IN_BITS_PER_SAMPLE]),
                .o_dout (w_conv[i*OUT_BITS_PER_SAMPLE +: OUT_BITS_PER_SAMPLE]),
                .o_ovf  (w_ovf_lane[i])
            );
        end
    endgenerate

    assign w_accept = s_axis.valid & r_s_ready;
    assign w_pop    = (r_state != ST_EMPTY) & m_axis.ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_pop && w_accept) begin
                    w_load_out_in = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept) begin
                    // Output is stalled: park the new beat behind it.
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_EMPTY;
            r_s_ready   <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Ready is decoded from the next state so it is a flop output.
            r_s_ready <= (w_state_nxt != ST_TWO);
            if (w_load_out_in) begin
                r_out_data <= w_conv;
                r_out_last <= s_axis.last;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
                r_out_last <= r_skid_last;
            end
            if (w_load_skid) begin
                r_skid_data <= w_conv;
                r_skid_last <= s_axis.last;
            end
            if (w_accept && (|w_ovf_lane)) begin
                r_ovf <= 1'b1;
            end else if (ovf_clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign s_axis.ready = r_s_ready;
    assign m_axis.valid = (r_state != ST_EMPTY);
    assign m_axis.data  = r_out_data;
    assign m_axis.last  = r_out_last;
    assign ovf_sticky   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_util_axis_pad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_util_axis_pad
//  Description : Self-checking bench for util_axis_pad. Ten parameter sets
//                run side by side; each has a stimulus queue, an expected
//                queue and an occupancy/sticky model. Directed vectors carry
//                hand-derived expectations, random beats take theirs from an
//                arithmetic reference of the conversion rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_util_axis_pad;

    localparam int NC = 10;
    localparam int C_IN  [NC] = '{12, 12, 12, 16, 16, 16, 16, 16, 16, 16};
    localparam int C_OUT [NC] = '{16, 16, 16, 12,  8,  8, 16, 12,  8, 12};
    localparam int C_P   [NC] = '{ 1,  0,  1,  0,  1,  1,  0,  0,  1,  0};
    localparam int C_SE  [NC] = '{ 1,  1,  0,  1,  1,  0,  1,  0,  1,  1};
    localparam int C_RND [NC] = '{ 0,  0,  0,  1,  0,  0,  0,  1,  0,  0};
    localparam int C_SAT [NC] = '{ 0,  0,  0,  0,  1,  1,  0,  0,  0,  0};

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_valid    [NC];
    logic        s_last     [NC];
    logic [31:0] s_data     [NC];
    logic        s_ready    [NC];
    logic        m_valid    [NC];
    logic        m_ready    [NC];
    logic        m_last     [NC];
    logic [31:0] m_data     [NC];
    logic        ovf_sticky [NC];
    logic        ovf_clear  [NC];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NC; g++) begin : g_dut
            localparam int IW = C_IN[g];
            localparam int OW = C_OUT[g];
            util_axis_pad_if #(.DATA_W(2*IW)) s_if ();
            util_axis_pad_if #(.DATA_W(2*OW)) m_if ();

            assign s_if.valid = s_valid[g];
            assign s_if.data  = s_data[g][2*IW-1:0];
            assign s_if.last  = s_last[g];
            assign s_ready[g] = s_if.ready;
            assign m_if.ready = m_ready[g];
            assign m_valid[g] = m_if.valid;
            assign m_last[g]  = m_if.last;
            assign m_data[g]  = 32'(m_if.data);

            util_axis_pad #(
                .NUM_OF_SAMPLES       (2),
                .IN_BITS_PER_SAMPLE   (IW),
                .OUT_BITS_PER_SAMPLE  (OW),
                .PADDING_TO_MSB_LSB_N (C_P[g]),
                .SIGN_EXTEND          (C_SE[g]),
                .ROUND                (C_RND[g]),
                .SATURATE             (C_SAT[g])
            ) u_dut (
                .clk        (clk),
                .resetn     (resetn),
                .s_axis     (s_if),
                .m_axis     (m_if),
                .ovf_sticky (ovf_sticky[g]),
                .ovf_clear  (ovf_clear[g])
            );
        end
    endgenerate

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [31:0] exp;
        logic        exp_ovf;
        logic        clr;
    } beat_t;

    beat_t stim_q [NC][$];
    beat_t exp_q  [NC][$];
    int    occ     [NC];
    logic  sticky  [NC];
    int    pop_cnt [NC];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference conversion: treat the sample as an integer, then widen,
    // divide (floor or round-half-up) or wrap/clamp and re-encode.
    function automatic logic [15:0] ref_f(input int g, input logic [15:0] x, output logic ov);
        longint v, r, mx, mn;
        int     iw, ow, d;
        iw = C_IN[g];
        ow = C_OUT[g];
        ov = 1'b0;
        v  = longint'(x);
        if (C_SE[g] != 0 && v >= (longint'(1) << (iw - 1))) v = v - (longint'(1) << iw);
        mx = (C_SE[g] != 0) ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
        mn = (C_SE[g] != 0) ? -(longint'(1) << (ow - 1)) : 0;
        if (iw <= ow) begin
            r = (C_P[g] != 0 || iw == ow) ? v : v * (longint'(1) << (ow - iw));
        end else begin
            d = iw - ow;
            if (C_P[g] == 0) begin
                if (C_RND[g] != 0) begin
                    r = (v + (longint'(1) << (d - 1))) >>> d;
                    if (r > mx) begin r = mx; ov = 1'b1; end
                end else begin
                    r = v >>> d;
                end
            end else if (C_SAT[g] != 0) begin
                r = v;
                if (v > mx) begin r = mx; ov = 1'b1; end
                else if (v < mn) begin r = mn; ov = 1'b1; end
            end else begin
                r = v;
            end
        end
        return 16'(r & ((longint'(1) << ow) - 1));
    endfunction

    function automatic beat_t pack_beat(input int g, input logic [15:0] s0, input logic [15:0] s1,
                                        input logic [15:0] e0, input logic [15:0] e1,
                                        input logic ov, input logic last, input logic clr);
        beat_t b;
        b.data    = (32'(s1) << C_IN[g]) | 32'(s0);
        b.exp     = (32'(e1) << C_OUT[g]) | 32'(e0);
        b.exp_ovf = ov;
        b.last    = last;
        b.clr     = clr;
        return b;
    endfunction

    task automatic add_dir(input int g, input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic ov, input logic last, input logic clr);
        stim_q[g].push_back(pack_beat(g, s0, s1, e0, e1, ov, last, clr));
    endtask

    task automatic add_random(input int g, input int n);
        logic [15:0] s0, s1, e0, e1;
        logic        o0, o1;
        for (int i = 0; i < n; i++) begin
            s0 = 16'($urandom_range(0, (1 << C_IN[g]) - 1));
            s1 = 16'($urandom_range(0, (1 << C_IN[g]) - 1));
            e0 = ref_f(g, s0, o0);
            e1 = ref_f(g, s1, o1);
            stim_q[g].push_back(pack_beat(g, s0, s1, e0, e1, o0 | o1,
                                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0)));
        end
    endtask

    // One cycle: check outputs against the model, drive the next inputs,
    // then account for the handshakes the coming posedge will perform.
    // rmode: 0 = m_ready always 1, 1 = pattern 1,0,0,1, 2 = random.
    task automatic step(input int rmode, input int k);
        @(negedge clk);
        for (int g = 0; g < NC; g++) begin
            logic  acc, pop;
            beat_t b, e;
            check($sformatf("cfg%0d m_valid", g), 32'(m_valid[g]), 32'(occ[g] > 0));
            check($sformatf("cfg%0d s_ready", g), 32'(s_ready[g]), 32'(occ[g] < 2));
            check($sformatf("cfg%0d ovf_sticky", g), 32'(ovf_sticky[g]), 32'(sticky[g]));
            b = '0;
            if (stim_q[g].size() > 0 && (rmode != 2 || $urandom_range(0, 3) != 0)) begin
                b            = stim_q[g][0];
                s_valid[g]   = 1'b1;
                s_data[g]    = b.data;
                s_last[g]    = b.last;
                ovf_clear[g] = b.clr;
            end else begin
                s_valid[g]   = 1'b0;
                s_data[g]    = $urandom;
                s_last[g]    = 1'($urandom);
                ovf_clear[g] = (rmode == 2) && ($urandom_range(0, 15) == 0);
            end
            case (rmode)
                0:       m_ready[g] = 1'b1;
                1:       m_ready[g] = (k % 4 == 0) || (k % 4 == 3);
                default: m_ready[g] = 1'($urandom);
            endcase
            acc = s_valid[g] && s_ready[g];
            pop = m_valid[g] && m_ready[g];
            if (pop && exp_q[g].size() > 0) begin
                e = exp_q[g].pop_front();
                pop_cnt[g]++;
                check($sformatf("cfg%0d m_data", g), m_data[g], e.exp);
                check($sformatf("cfg%0d m_last", g), 32'(m_last[g]), 32'(e.last));
            end
            if (acc && b.exp_ovf) sticky[g] = 1'b1;
            else if (ovf_clear[g]) sticky[g] = 1'b0;
            if (acc) exp_q[g].push_back(stim_q[g].pop_front());
            occ[g] = occ[g] + int'(acc) - int'(pop);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int g = 0; g < NC; g++) begin
            s_valid[g]   = 1'b1;
            s_data[g]    = $urandom;
            s_last[g]    = 1'b1;
            m_ready[g]   = 1'b1;
            ovf_clear[g] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < NC; g++) begin
                check($sformatf("cfg%0d rst m_valid", g), 32'(m_valid[g]), 32'd0);
                check($sformatf("cfg%0d rst s_ready", g), 32'(s_ready[g]), 32'd0);
                check($sformatf("cfg%0d rst m_data", g), m_data[g], 32'd0);
                check($sformatf("cfg%0d rst m_last", g), 32'(m_last[g]), 32'd0);
                check($sformatf("cfg%0d rst ovf", g), 32'(ovf_sticky[g]), 32'd0);
            end
        end
        for (int g = 0; g < NC; g++) begin
            stim_q[g].delete();
            exp_q[g].delete();
            occ[g]     = 0;
            sticky[g]  = 1'b0;
            pop_cnt[g] = 0;
            s_valid[g] = 1'b0;
        end
        resetn = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        for (int g = 0; g < NC; g++) begin
            check($sformatf("cfg%0d %s drained", g, tag), 32'(stim_q[g].size() + exp_q[g].size()), 32'd0);
        end
    endtask

    initial begin
        resetn = 1'b0;
        do_reset();

        // Widening 12 -> 16
        add_dir(0, 16'h800, 16'h7FF, 16'hF800, 16'h07FF, 1'b0, 1'b1, 1'b0);
        add_dir(1, 16'h800, 16'h7FF, 16'h8000, 16'h7FF0, 1'b0, 1'b1, 1'b0);
        add_dir(2, 16'h800, 16'h7FF, 16'h0800, 16'h07FF, 1'b0, 1'b1, 1'b0);
        // Round-half-up 16 -> 12; overflow beat arrives with a clear (set wins),
        // then a clean beat with a clear drops the flag.
        add_dir(3, 16'h1238, 16'h1237, 16'h124, 16'h123, 1'b0, 1'b0, 1'b0);
        add_dir(3, 16'hFFF8, 16'h7FF8, 16'h000, 16'h7FF, 1'b1, 1'b0, 1'b1);
        add_dir(3, 16'h0000, 16'h0000, 16'h000, 16'h000, 1'b0, 1'b1, 1'b1);
        // Saturating MSB removal 16 -> 8
        add_dir(4, 16'hFF80, 16'h0005, 16'h80, 16'h05, 1'b0, 1'b0, 1'b0);
        add_dir(4, 16'h0123, 16'h0000, 16'h7F, 16'h00, 1'b1, 1'b0, 1'b0);
        add_dir(4, 16'h0001, 16'hFFFF, 16'h01, 16'hFF, 1'b0, 1'b0, 1'b1);
        add_dir(4, 16'hFE00, 16'h0042, 16'h80, 16'h42, 1'b1, 1'b1, 1'b0);
        add_dir(5, 16'h0100, 16'h00FF, 16'hFF, 16'hFF, 1'b1, 1'b1, 1'b0);
        // Backpressure: beats 1..8, last on 8
        for (int i = 1; i <= 8; i++) begin
            add_dir(6, 16'(i), 16'h0, 16'(i), 16'h0, 1'b0, (i == 8), 1'b0);
        end
        for (int k = 0; k < 40; k++) step(1, k);
        check_drained("directed");

        // Full throughput: 8 beats presented back to back, m_ready held high.
        pop_cnt[6] = 0;
        for (int i = 1; i <= 8; i++) begin
            add_dir(6, 16'(i + 8), 16'(i), 16'(i + 8), 16'(i), 1'b0, (i == 8), 1'b0);
        end
        for (int k = 0; k < 9; k++) step(0, k);
        check("cfg6 throughput beats out", 32'(pop_cnt[6]), 32'd8);
        for (int k = 0; k < 4; k++) step(0, k);

        // Random traffic, interrupted by a reset with beats still held.
        for (int g = 0; g < NC; g++) add_random(g, 400);
        for (int k = 0; k < 300; k++) step(2, k);
        do_reset();
        for (int g = 0; g < NC; g++) add_random(g, 150);
        for (int k = 0; k < 1000; k++) step(2, k);
        for (int k = 0; k < 60; k++) step(0, k);
        check_drained("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
